// File: rtl/mips_ctrl_pkg.sv
//------------------------------------------------------------------------------
// mips_ctrl_pkg
//   Shared types and constants for the multicycle MIPS main controller:
//   state encodings, opcodes, ALUOp/PCSrc/ALUSrcB codes and the control word.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mips_ctrl_pkg;

    // Architectural state encodings (5 bits; wider state ports zero-extend)
    typedef enum logic [4:0] {
        S_FETCH   = 5'd0,
        S_DECODE  = 5'd1,
        S_MEMADR  = 5'd2,
        S_MEMRD   = 5'd3,
        S_MEMWB   = 5'd4,
        S_MEMWR   = 5'd5,
        S_RTYPEEX = 5'd6,
        S_RTYPEWB = 5'd7,
        S_BEQEX   = 5'd8,
        S_ADDIEX  = 5'd9,
        S_IMMWB   = 5'd10,
        S_JEX     = 5'd11,
        S_BNEEX   = 5'd12,
        S_ANDIEX  = 5'd13,
        S_ORIEX   = 5'd14,
        S_SLTIEX  = 5'd15,
        S_EXCEPT  = 5'd16
    } state_e;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ALUOp codes
    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_FUNCT = 3'b010;
    localparam logic [2:0] ALUOP_AND   = 3'b011;
    localparam logic [2:0] ALUOP_OR    = 3'b100;
    localparam logic [2:0] ALUOP_SLT   = 3'b101;

    // PCSrc codes
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_EXC    = 2'b11;

    // ALUSrcB codes
    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    // Full datapath control word
    typedef struct packed {
        logic       mem_to_reg;
        logic       reg_dst;
        logic       iord;
        logic       alu_src_a;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       pc_write;
        logic       branch_eq;
        logic       branch_ne;
        logic       reg_write;
        logic       illegal_op;
        logic [1:0] pc_src;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
    } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/mips_ctrl_outdec.sv
//------------------------------------------------------------------------------
// mips_ctrl_outdec
//   Purely combinational decoder from controller state (+ memory ready) to
//   the datapath control word.
//   Ports: state_i     - current state encoding (STATE_W bits)
//          mem_ready_i - effective memory-ready (gates IRWrite/PCWrite in FETCH)
//          ctrl_o      - control word
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W = 5
) (
    input  logic [STATE_W-1:0] state_i,
    input  logic               mem_ready_i,
    output ctrl_t              ctrl_o
);

    logic   valid;
    state_e st;

    // Any bit above the 5-bit encoding set means an unused encoding
    assign valid = ((state_i >> 5) == '0);
    assign st    = state_e'(state_i[4:0]);

    always_comb begin
        ctrl_o = '0;
        if (valid) begin
            case (st)
                S_FETCH: begin
                    ctrl_o.mem_read  = 1'b1;
                    ctrl_o.alu_src_b = SRCB_FOUR;
                    ctrl_o.alu_op    = ALUOP_ADD;
                    // Mealy gating: only latch IR / advance PC once memory delivers
                    ctrl_o.ir_write  = mem_ready_i;
                    ctrl_o.pc_write  = mem_ready_i;
                end
                S_DECODE: ctrl_o.alu_src_b = SRCB_IMMSH;
                S_MEMADR: begin
                    ctrl_o.alu_src_a = 1'b1;
                    ctrl_o.alu_src_b = SRCB_IMM;
                end
                S_MEMRD: begin
                    ctrl_o.iord     = 1'b1;
                    ctrl_o.mem_read = 1'b1;
                end
                S_MEMWB: begin
                    ctrl_o.mem_to_reg = 1'b1;
                    ctrl_o.reg_write  = 1'b1;
                end
                S_MEMWR: begin
                    ctrl_o.iord      = 1'b1;
                    ctrl_o.mem_write = 1'b1;
                end
                S_RTYPEEX: begin
                    ctrl_o.alu_src_a = 1'b1;
                    ctrl_o.alu_op    = ALUOP_FUNCT;
                end
                S_RTYPEWB: begin
                    ctrl_o.reg_dst   = 1'b1;
                    ctrl_o.reg_write = 1'b1;
                end
                S_BEQEX, S_BNEEX: begin
                    ctrl_o.alu_src_a = 1'b1;
                    ctrl_o.alu_op    = ALUOP_SUB;
                    ctrl_o.pc_src    = PCSRC_ALUOUT;
                    ctrl_o.branch_eq = (st == S_BEQEX);
                    ctrl_o.branch_ne = (st == S_BNEEX);
                end
                S_ADDIEX, S_ANDIEX, S_ORIEX, S_SLTIEX: begin
                    ctrl_o.alu_src_a = 1'b1;
                    ctrl_o.alu_src_b = SRCB_IMM;
                    case (st)
                        S_ANDIEX: ctrl_o.alu_op = ALUOP_AND;
                        S_ORIEX:  ctrl_o.alu_op = ALUOP_OR;
                        S_SLTIEX: ctrl_o.alu_op = ALUOP_SLT;
                        default:  ctrl_o.alu_op = ALUOP_ADD;
                    endcase
                end
                S_IMMWB: ctrl_o.reg_write = 1'b1;
                S_JEX: begin
                    ctrl_o.pc_src   = PCSRC_JUMP;
                    ctrl_o.pc_write = 1'b1;
                end
                S_EXCEPT: begin
                    ctrl_o.pc_src     = PCSRC_EXC;
                    ctrl_o.pc_write   = 1'b1;
                    ctrl_o.illegal_op = 1'b1;
                end
                default: ctrl_o = '0;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/mips_multicycle_controller.sv
//------------------------------------------------------------------------------
// mips_multicycle_controller
//   Multicycle MIPS main controller: state register and next-state logic.
//   Outputs are decoded combinationally from the state by mips_ctrl_outdec.
//   Ports: clk, rst (sync, active-low), opcode (instr[31:26]), mem_ready,
//          state (current encoding), datapath controls, illegal_op.
//   Parameters: MEM_HANDSHAKE (honour mem_ready), ENABLE_EXT (bne/andi/ori/
//          slti decoded), STATE_W (state width, must be >= 5).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mips_multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_HANDSHAKE = 1,
    parameter int ENABLE_EXT    = 1,
    parameter int STATE_W       = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic [STATE_W-1:0] state,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               IorD,
    output logic               ALUSrcA,
    output logic               IRWrite,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               PCWrite,
    output logic               BranchEQ,
    output logic               BranchNE,
    output logic               RegWrite,
    output logic [1:0]         PCSrc,
    output logic [1:0]         ALUSrcB,
    output logic [2:0]         ALUOp,
    output logic               illegal_op
);

    logic [STATE_W-1:0] state_q, state_d;
    logic               ready;
    logic               ext_en;
    logic               cur_valid;
    state_e             cur, nxt;
    ctrl_t              ctrl;

    assign ready     = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
    assign ext_en    = (ENABLE_EXT != 0);
    assign cur_valid = ((state_q >> 5) == '0);
    assign cur       = state_e'(state_q[4:0]);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        nxt = S_FETCH;
        if (cur_valid) begin
            case (cur)
                S_FETCH:  nxt = ready ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW: nxt = S_MEMADR;
                        OP_RTYPE:     nxt = S_RTYPEEX;
                        OP_BEQ:       nxt = S_BEQEX;
                        OP_ADDI:      nxt = S_ADDIEX;
                        OP_J:         nxt = S_JEX;
                        OP_BNE:       nxt = ext_en ? S_BNEEX  : S_EXCEPT;
                        OP_ANDI:      nxt = ext_en ? S_ANDIEX : S_EXCEPT;
                        OP_ORI:       nxt = ext_en ? S_ORIEX  : S_EXCEPT;
                        OP_SLTI:      nxt = ext_en ? S_SLTIEX : S_EXCEPT;
                        default:      nxt = S_EXCEPT;
                    endcase
                end
                S_MEMADR:  nxt = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:   nxt = ready ? S_MEMWB : S_MEMRD;
                S_MEMWB:   nxt = S_FETCH;
                S_MEMWR:   nxt = ready ? S_FETCH : S_MEMWR;
                S_RTYPEEX: nxt = S_RTYPEWB;
                S_RTYPEWB: nxt = S_FETCH;
                S_ADDIEX, S_ANDIEX, S_ORIEX, S_SLTIEX: nxt = S_IMMWB;
                default:   nxt = S_FETCH;
            endcase
        end
        state_d = STATE_W'(nxt);
    end

    mips_ctrl_outdec #(
        .STATE_W (STATE_W)
    ) u_outdec (
        .state_i     (state_q),
        .mem_ready_i (ready),
        .ctrl_o      (ctrl)
    );

    assign state      = state_q;
    assign MemtoReg   = ctrl.mem_to_reg;
    assign RegDst     = ctrl.reg_dst;
    assign IorD       = ctrl.iord;
    assign ALUSrcA    = ctrl.alu_src_a;
    assign IRWrite    = ctrl.ir_write;
    assign MemRead    = ctrl.mem_read;
    assign MemWrite   = ctrl.mem_write;
    assign PCWrite    = ctrl.pc_write;
    assign BranchEQ   = ctrl.branch_eq;
    assign BranchNE   = ctrl.branch_ne;
    assign RegWrite   = ctrl.reg_write;
    assign PCSrc      = ctrl.pc_src;
    assign ALUSrcB    = ctrl.alu_src_b;
    assign ALUOp      = ctrl.alu_op;
    assign illegal_op = ctrl.illegal_op;

endmodule

`default_nettype wire
